uart_rx_cfg: RTL and testbench
==============================

UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 Parameters SHALL be:
- MaxDataLength, 9, widest supported frame data width in bits.
- OverSample, 16, ticks per bit; even, at least 8.
- FifoDepth, 8, receive FIFO entries; power of 2.
- DivWidth, 16, width of the baud divisor.

REQ-002 Ports SHALL be:
- i_clk  in  1  single system clock; all logic on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_div  in  DivWidth  clock cycles per oversample tick minus 1.
- i_data_len  in  4  data bits per frame; legal range 5..MaxDataLength.
- i_parity  in  2  parity mode: 00 none, 01 even, 10 odd, 11 treated as none.
- i_stop2  in  1  1 = two stop bits expected.
- i_rx  in  1  asynchronous serial input; idles high.
- i_rx_req  in  1  pop request for the FIFO head.
- i_err_clr  in  1  clears the sticky o_overrun.
- o_rx_data  out  MaxDataLength  FIFO head data, LSB = first bit received, unused MSBs 0.
- o_rx_rdy  out  1  FIFO not empty.
- o_parity_err  out  1  parity-error flag of the FIFO head entry.
- o_frame_err  out  1  stop-bit-error flag of the FIFO head entry.
- o_overrun  out  1  sticky; a frame was dropped because the FIFO was full.
- o_break  out  1  one-cycle pulse on break detection.
- o_rts  out  1  flow control; 1 = FIFO holds at most FifoDepth-2 entries.

Function
REQ-003 i_rx SHALL pass through a 2-flop synchroniser before any use.
REQ-004 The tick counter SHALL count 0..i_div, emit a one-cycle tick on wrap, and tick every cycle when i_div=0.
REQ-005 The tick counter SHALL restart at 0 on every synchronised falling edge seen in IDLE.
REQ-006 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
REQ-007 IDLE->START SHALL occur on a synchronised falling edge; at that point i_data_len, i_parity and i_stop2 are latched for the whole frame.
REQ-008 Each bit SHALL be decided by a 2-of-3 majority of samples taken at ticks OS/2-1, OS/2 and OS/2+1 of that bit.
REQ-009 START SHALL return to IDLE if the start-bit majority is 1 (glitch rejection), with no FIFO write and no flag raised.
REQ-010 DATA SHALL shift in exactly the latched data length, LSB first, then go to PARITY if parity is enabled, else to STOP.
REQ-011 The parity error flag SHALL be set on mismatch: even mode requires an even count of ones over data plus parity bit; odd mode requires an odd count.
REQ-012 STOP SHALL check one stop bit, or two if i_stop2 was latched; any stop sample of 0 sets the frame error flag.
REQ-013 Break SHALL be detected when all data bits, the parity bit (if enabled) and the first stop bit are 0.
- Break SHALL pulse o_break for one cycle, write nothing to the FIFO, and go to WAIT_IDLE.
REQ-014 WAIT_IDLE SHALL be entered after any frame error and SHALL hold until the synchronised line reads 1 for one full bit time, then go to IDLE.
REQ-015 Frame write: at the final stop-bit decision, {data, parity error, frame error} SHALL be written on the next edge.
- o_rx_rdy SHALL rise on the cycle after that write edge.
REQ-016 The FIFO SHALL be first-word-fall-through: o_rx_data, o_parity_err and o_frame_err reflect the head whenever o_rx_rdy=1, and are 0 when the FIFO is empty.
REQ-017 A pop SHALL occur when i_rx_req=1 and o_rx_rdy=1; i_rx_req while empty SHALL be ignored.
REQ-018 Write and pop in the same cycle SHALL both be accepted, including when the FIFO is full, leaving the count unchanged.
REQ-019 A write to a full FIFO without a simultaneous pop SHALL drop the frame and set o_overrun.
REQ-020 o_overrun SHALL clear on i_err_clr, except that a simultaneous new overrun wins and keeps it set.
REQ-021 Pointers SHALL wrap modulo FifoDepth; the count register SHALL be log2(FifoDepth)+1 bits wide.

Reset
REQ-022 On i_rst=1 at a clock edge:
- FSM to IDLE; tick counter and FIFO pointers/count to 0; synchroniser flops to 1.
- Outputs: o_rx_rdy, o_rx_data, o_parity_err, o_frame_err, o_overrun, o_break all 0.
- o_rts = 1 from the cycle after reset.
REQ-023 Reset mid-frame SHALL discard the partial frame, and the block SHALL accept a new frame starting two or more cycles after reset deasserts.

Verification
REQ-024 i_div=3, len 8, no parity, 1 stop bit, send 0xA5 -> o_rx_data=0x0A5, both error flags 0, o_rx_rdy within one bit time after the stop-bit middle.
REQ-025 len 7, even parity, send 0x41 with parity bit 1 -> o_parity_err=1, data 0x41; repeat with parity bit 0 -> o_parity_err=0.
REQ-026 i_stop2=1, second stop bit driven 0, data 0x3C -> entry 0x3C with o_frame_err=1; the following good frame 0x55 is received cleanly.
REQ-027 Line held low for 12 bit times -> one o_break pulse, o_rx_rdy stays 0; after line high, frame 0x0F is received correctly.
REQ-028 FifoDepth=8, send 9 frames without popping -> o_rts falls at count 7, o_overrun=1 after frame 9, FIFO returns frames 1..8 in order; i_err_clr then clears o_overrun.
REQ-029 i_rx low for 20 cycles at i_div=3 -> no write, FSM back in IDLE, next frame 0x96 is received correctly.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// UART receiver: runtime-configurable frame format, majority-vote sampling, and a FWFT receive FIFO.
// Ports: i_clk/i_rst, i_div baud divisor, i_data_len/i_parity/i_stop2 frame format, i_rx serial in,
//   i_rx_req pop, i_err_clr overrun clear, o_rx_* FIFO head, o_overrun, o_break, o_rts.
module uart_rx_cfg #(
  parameter int MaxDataLength = 9,
  parameter int OverSample    = 16,
  parameter int FifoDepth     = 8,
  parameter int DivWidth      = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [DivWidth-1:0]      i_div,
  input  logic [3:0]               i_data_len,
  input  logic [1:0]               i_parity,
  input  logic                     i_stop2,
  input  logic                     i_rx,
  input  logic                     i_rx_req,
  input  logic                     i_err_clr,
  output logic [MaxDataLength-1:0] o_rx_data,
  output logic                     o_rx_rdy,
  output logic                     o_parity_err,
  output logic                     o_frame_err,
  output logic                     o_overrun,
  output logic                     o_break,
  output logic                     o_rts
);

  localparam int OSW = $clog2(OverSample);
  localparam int PW  = $clog2(FifoDepth);
  localparam int EW  = MaxDataLength + 2;

  localparam logic [OSW-1:0] C_LO  = OSW'(OverSample / 2 - 1);
  localparam logic [OSW-1:0] C_MID = OSW'(OverSample / 2);
  localparam logic [OSW-1:0] C_HI  = OSW'(OverSample / 2 + 1);
  localparam logic [OSW-1:0] C_END = OSW'(OverSample - 1);
  localparam logic [PW:0]    C_FULL = (PW+1)'(FifoDepth);
  localparam logic [PW:0]    C_RTS  = (PW+1)'(FifoDepth - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                     r_sync1;
  logic                     r_sync2;
  logic                     r_rx_d;
  logic [DivWidth-1:0]      r_div_cnt;
  logic [OSW-1:0]           r_os_cnt;
  logic                     r_s0;
  logic                     r_s1;
  logic [3:0]               r_len;
  logic [1:0]               r_pmode;
  logic                     r_stop2;
  logic [MaxDataLength-1:0] r_data;
  logic [3:0]               r_bit_cnt;
  logic                     r_zero;
  logic                     r_perr;
  logic                     r_ferr;
  logic                     r_stop_idx;
  logic [EW-1:0]            r_mem [FifoDepth];
  logic [PW-1:0]            r_wr_ptr;
  logic [PW-1:0]            r_rd_ptr;
  logic [PW:0]              r_count;
  logic                     r_overrun;
  logic                     r_break;

  logic          w_tick;
  logic          w_fall;
  logic          w_dec;
  logic          w_bit;
  logic          w_pen;
  logic          w_last;
  logic          w_par;
  logic          w_perr_now;
  logic          w_ferr_now;
  logic [3:0]    w_len;
  logic          w_wr;
  logic          w_brk;
  logic          w_to_wait;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_ovr;
  logic [EW-1:0] w_head;

  // >= keeps a divisor change from stranding the counter above i_div
  assign w_tick = (r_div_cnt >= i_div);
  assign w_fall = r_rx_d & ~r_sync2;
  assign w_dec  = w_tick & (r_os_cnt == C_HI);
  // third sample is taken live at the decision tick
  assign w_bit  = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
  assign w_pen  = (r_pmode == 2'b01) | (r_pmode == 2'b10);
  assign w_last = (r_bit_cnt == r_len - 4'd1);
  assign w_par  = (^r_data) ^ w_bit;
  assign w_perr_now = (r_pmode == 2'b01) ? w_par : ~w_par;
  assign w_ferr_now = r_ferr | ~w_bit;

  assign w_len = (i_data_len < 4'd5) ? 4'd5 :
                 (i_data_len > 4'(MaxDataLength)) ? 4'(MaxDataLength) :
                 i_data_len;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr        = 1'b0;
    w_brk       = 1'b0;
    w_to_wait   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_dec) w_state_nxt = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_dec && w_last)
          w_state_nxt = w_pen ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_dec) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_dec) begin
          if (!r_stop_idx && r_zero && !w_bit) begin
            w_brk       = 1'b1;
            w_to_wait   = 1'b1;
            w_state_nxt = S_WAIT;
          end else if (r_stop_idx || !r_stop2) begin
            w_wr = 1'b1;
            if (w_ferr_now) begin
              w_to_wait   = 1'b1;
              w_state_nxt = S_WAIT;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
      end
      S_WAIT: begin
        if (w_tick && r_sync2 && r_os_cnt == C_END)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_rx_d     <= 1'b1;
      r_div_cnt  <= '0;
      r_os_cnt   <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_len      <= 4'd8;
      r_pmode    <= 2'b00;
      r_stop2    <= 1'b0;
      r_data     <= '0;
      r_bit_cnt  <= '0;
      r_zero     <= 1'b1;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_stop_idx <= 1'b0;
      r_break    <= 1'b0;
    end else begin
      r_sync1 <= i_rx;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
      r_break <= w_brk;

      if (r_state == S_IDLE && w_fall) r_div_cnt <= '0;
      else if (w_tick)                  r_div_cnt <= '0;
      else                              r_div_cnt <= r_div_cnt + 1'b1;

      unique case (r_state)
        S_IDLE: begin
          if (w_fall) r_os_cnt <= '0;
        end
        // counts ticks of continuous idle-high line
        S_WAIT: begin
          if (!r_sync2)    r_os_cnt <= '0;
          else if (w_tick) r_os_cnt <= (r_os_cnt == C_END) ? '0 : r_os_cnt + 1'b1;
        end
        default: begin
          if (w_to_wait)   r_os_cnt <= '0;
          else if (w_tick) r_os_cnt <= (r_os_cnt == C_END) ? '0 : r_os_cnt + 1'b1;
        end
      endcase

      if (w_tick && r_os_cnt == C_LO)  r_s0 <= r_sync2;
      if (w_tick && r_os_cnt == C_MID) r_s1 <= r_sync2;

      if (r_state == S_IDLE && w_fall) begin
        r_len      <= w_len;
        r_pmode    <= i_parity;
        r_stop2    <= i_stop2;
        r_data     <= '0;
        r_bit_cnt  <= '0;
        r_zero     <= 1'b1;
        r_perr     <= 1'b0;
        r_ferr     <= 1'b0;
        r_stop_idx <= 1'b0;
      end

      if (r_state == S_DATA && w_dec) begin
        r_data    <= r_data | ({{(MaxDataLength-1){1'b0}}, w_bit} << r_bit_cnt);
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (w_bit) r_zero <= 1'b0;
      end

      if (r_state == S_PARITY && w_dec) begin
        r_perr <= w_perr_now;
        if (w_bit) r_zero <= 1'b0;
      end

      if (r_state == S_STOP && w_dec) begin
        r_ferr     <= w_ferr_now;
        r_stop_idx <= 1'b1;
      end
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL);
  assign w_pop   = i_rx_req & ~w_empty;
  assign w_push  = w_wr & (~w_full | w_pop);
  assign w_ovr   = w_wr & w_full & ~w_pop;

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_data, r_perr, w_ferr_now};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      if (w_ovr)          r_overrun <= 1'b1;
      else if (i_err_clr) r_overrun <= 1'b0;
    end
  end

  assign w_head       = r_mem[r_rd_ptr];
  assign o_rx_rdy     = ~w_empty;
  assign o_rx_data    = w_empty ? '0 : w_head[EW-1:2];
  assign o_parity_err = w_empty ? 1'b0 : w_head[1];
  assign o_frame_err  = w_empty ? 1'b0 : w_head[0];
  assign o_overrun    = r_overrun;
  assign o_break      = r_break;
  assign o_rts        = (r_count <= C_RTS);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: serial frame driver, queue scoreboard, auto-popping monitor.
// Expected FIFO entries come from a frame-level model of the serial format.
module tb_uart_rx_cfg;
  localparam int OS    = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        i_rst;
  logic [15:0] i_div;
  logic [3:0]  i_data_len;
  logic [1:0]  i_parity;
  logic        i_stop2;
  logic        i_rx;
  logic        i_rx_req;
  logic        i_err_clr;
  logic [8:0]  o_rx_data;
  logic        o_rx_rdy;
  logic        o_parity_err;
  logic        o_frame_err;
  logic        o_overrun;
  logic        o_break;
  logic        o_rts;

  int          total = 0;
  int          bad   = 0;
  logic [10:0] sb[$];
  bit          pop_en = 1'b1;
  int          exp_brk = 0;
  int          seen_brk = 0;
  bit          exp_ovr = 1'b0;
  int          div = 3;

  always #5 clk = ~clk;

  uart_rx_cfg dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_div        (i_div),
    .i_data_len   (i_data_len),
    .i_parity     (i_parity),
    .i_stop2      (i_stop2),
    .i_rx         (i_rx),
    .i_rx_req     (i_rx_req),
    .i_err_clr    (i_err_clr),
    .o_rx_data    (o_rx_data),
    .o_rx_rdy     (o_rx_rdy),
    .o_parity_err (o_parity_err),
    .o_frame_err  (o_frame_err),
    .o_overrun    (o_overrun),
    .o_break      (o_break),
    .o_rts        (o_rts)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic bits(input logic b, input int n);
    i_rx = b;
    repeat (n * OS * (div + 1)) @(negedge clk);
  endtask

  task automatic set_div(input int d);
    div   = d;
    i_div = 16'(d);
  endtask

  task automatic frame(input int d, input int len, input int pm,
                       input bit pflip, input bit s2,
                       input bit st1, input bit st2);
    int dm;
    bit pen;
    bit pb;
    bit perr;
    bit ferr;
    dm   = d & ((1 << len) - 1);
    pen  = (pm == 1) || (pm == 2);
    pb   = pen ? (($countones(dm) % 2 == 1) ^ (pm == 2) ^ pflip) : 1'b0;
    perr = pen && pflip;
    ferr = !st1 || (s2 && !st2);
    i_data_len = 4'(len);
    i_parity   = 2'(pm);
    i_stop2    = s2;
    if (dm == 0 && !pb && !st1) exp_brk++;
    else if (!pop_en && sb.size() == DEPTH) exp_ovr = 1'b1;
    else sb.push_back({9'(dm), perr, ferr});
    bits(1'b0, 1);
    for (int i = 0; i < len; i++) bits(1'((dm >> i) & 1), 1);
    if (pen) bits(pb, 1);
    bits(st1, 1);
    if (s2) bits(st2, 1);
    i_rx = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 5000; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    i_rx_req = 1'b0;
    forever begin
      @(negedge clk);
      if (i_rx_req) begin
        i_rx_req = 1'b0;
      end else if (pop_en && o_rx_rdy) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_entry got=%0h want=none",
                   {o_rx_data, o_parity_err, o_frame_err});
        end else begin
          chk("rx_entry", {o_rx_data, o_parity_err, o_frame_err}, sb.pop_front());
        end
        i_rx_req = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (o_break === 1'b1) seen_brk++;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    i_rst = 1'b1;
    i_rx = 1'b1;
    i_data_len = 4'd8;
    i_parity = 2'b00;
    i_stop2 = 1'b0;
    i_err_clr = 1'b0;
    set_div(3);
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", o_rx_rdy, 0);
    chk("rst_rts", o_rts, 1);
    chk("rst_ovr", o_overrun, 0);
    chk("rst_brk", o_break, 0);
    chk("rst_data", o_rx_data, 0);
    chk("rst_perr", o_parity_err, 0);
    chk("rst_ferr", o_frame_err, 0);
    bits(1'b1, 1);

    frame(32'hA5, 8, 0, 0, 0, 1, 1);
    chk("latency", sb.size(), 0);
    bits(1'b1, 2);

    frame(32'h41, 7, 1, 1, 0, 1, 1);
    bits(1'b1, 2);
    frame(32'h41, 7, 1, 0, 0, 1, 1);
    bits(1'b1, 2);

    frame(32'h3C, 8, 0, 0, 1, 1, 0);
    bits(1'b1, 2);
    frame(32'h55, 8, 0, 0, 1, 1, 1);
    bits(1'b1, 2);

    i_data_len = 4'd8;
    i_parity = 2'b00;
    i_stop2 = 1'b0;
    exp_brk++;
    bits(1'b0, 12);
    bits(1'b1, 2);
    chk("break_cnt", seen_brk, exp_brk);
    chk("break_rdy", o_rx_rdy, 0);
    frame(32'h0F, 8, 0, 0, 0, 1, 1);
    bits(1'b1, 2);

    i_rx = 1'b0;
    repeat (20) @(negedge clk);
    bits(1'b1, 3);
    chk("glitch_rdy", o_rx_rdy, 0);
    frame(32'h96, 8, 0, 0, 0, 1, 1);
    bits(1'b1, 2);

    drain();
    bits(1'b0, 1);
    bits(1'b1, 1);
    bits(1'b0, 1);
    i_rx = 1'b1;
    i_rst = 1'b1;
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_rdy", o_rx_rdy, 0);
    chk("mid_rst_rts", o_rts, 1);
    repeat (2) @(negedge clk);
    frame(32'h5A, 8, 0, 0, 0, 1, 1);
    bits(1'b1, 2);

    drain();
    pop_en = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      frame(k * 17 + 3, 8, 0, 0, 0, 1, 1);
      bits(1'b1, 2);
      if (k <= DEPTH) chk("rts_fill", o_rts, (k <= DEPTH - 2) ? 1 : 0);
    end
    chk("ovr_set", o_overrun, exp_ovr);
    chk("ovr_rts", o_rts, 0);
    pop_en = 1'b1;
    drain();
    chk("ovr_hold", o_overrun, 1);
    chk("rts_back", o_rts, 1);
    i_err_clr = 1'b1;
    @(negedge clk);
    i_err_clr = 1'b0;
    exp_ovr = 1'b0;
    @(negedge clk);
    chk("ovr_clr", o_overrun, exp_ovr);

    for (int n = 0; n < 16; n++) begin
      int dv;
      dv = $urandom_range(1, 3);
      set_div(dv);
      bits(1'b1, 1);
      frame($urandom_range(0, 511), $urandom_range(5, 9), $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0));
      bits(1'b1, 3);
    end

    drain();
    chk("break_final", seen_brk, exp_brk);
    chk("ovr_final", o_overrun, exp_ovr);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
